rst_seq_sonata: RTL and testbench

Reset sequencer that consumes the system clock plus the PLL lock and board reset signals produced by the clock generator. It synchronises and debounces these inputs, enforces a minimum reset hold, and releases peripheral then core resets in a fixed order. It re-enters reset on PLL lock loss, a board button press, or a software request, and records the cause. Sits directly after the clock generator in the top level; its outputs drive all downstream reset inputs in the system clock domain.

---
 rtl/rst_seq_sonata.sv | 141 ++++++++++++++
 tb/tb_rst_seq_sonata.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_sonata.sv
// Reset sequencer: synchronises PLL lock and board button, holds reset,
// then releases peripheral and core resets in order, recording the cause.
module rst_seq_sonata #(
    parameter int SyncStages     = 2,
    parameter int DebounceCycles = 1000,
    parameter int HoldCycles     = 64,
    parameter int StageGap       = 16,
    parameter int CntWidth       = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       locked_i,
    input  logic       ext_rst_ni,
    input  logic       sw_rst_req_i,
    output logic       rst_periph_no,
    output logic       rst_core_no,
    output logic [3:0] reset_reason_o,
    output logic [2:0] state_o
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        PERIPH_ON = 2'd2,
        RUN       = 2'd3
    } state_e;

    localparam logic [3:0] ReasonPor  = 4'b0001;
    localparam logic [3:0] ReasonLock = 4'b0010;
    localparam logic [3:0] ReasonExt  = 4'b0100;
    localparam logic [3:0] ReasonSw   = 4'b1000;

    localparam logic [CntWidth-1:0] DebLast  = CntWidth'(DebounceCycles - 1);
    localparam logic [CntWidth-1:0] HoldLast = CntWidth'(HoldCycles - 1);
    localparam logic [CntWidth-1:0] GapLast  = CntWidth'(StageGap - 1);

    logic [SyncStages-1:0] lock_sync_q, lock_sync_d;
    logic [SyncStages-1:0] ext_sync_q, ext_sync_d;
    logic                  deb_rel_q, deb_rel_d;
    logic [CntWidth-1:0]   deb_cnt_q, deb_cnt_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    state_e                state_q, state_d;
    logic                  periph_q, periph_d;
    logic                  core_q, core_d;
    logic [3:0]            reason_q, reason_d;

    logic lock_s, ext_s;
    logic lock_lost, ext_press, sw_hit, abort;

    assign lock_s = lock_sync_q[SyncStages-1];
    assign ext_s  = ext_sync_q[SyncStages-1];

    always_comb begin
        lock_sync_d = {lock_sync_q[SyncStages-2:0], locked_i};
        ext_sync_d  = {ext_sync_q[SyncStages-2:0], ext_rst_ni};
    end

    // Same threshold in both directions; any matching cycle restarts the count.
    always_comb begin
        deb_rel_d = deb_rel_q;
        deb_cnt_d = '0;
        if (ext_s != deb_rel_q) begin
            if (deb_cnt_q >= DebLast) begin
                deb_rel_d = ext_s;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    assign lock_lost = !lock_s;
    assign ext_press = !deb_rel_q;
    assign sw_hit    = sw_rst_req_i && (state_q == RUN);
    assign abort     = (state_q != WAIT_LOCK)
                     && (lock_lost || ext_press || sw_hit);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_sync_q <= '0;
            ext_sync_q  <= '0;
            deb_rel_q   <= 1'b1;
            deb_cnt_q   <= '0;
            cnt_q       <= '0;
            state_q     <= WAIT_LOCK;
            periph_q    <= 1'b0;
            core_q      <= 1'b0;
            reason_q    <= ReasonPor;
        end else begin
            lock_sync_q <= lock_sync_d;
            ext_sync_q  <= ext_sync_d;
            deb_rel_q   <= deb_rel_d;
            deb_cnt_q   <= deb_cnt_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            periph_q    <= periph_d;
            core_q      <= core_d;
            reason_q    <= reason_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_LOCK: if (lock_s && !ext_press) state_d = HOLD;
            HOLD: begin
                if (abort) state_d = WAIT_LOCK;
                else if (cnt_q >= HoldLast) state_d = PERIPH_ON;
            end
            PERIPH_ON: begin
                if (abort) state_d = WAIT_LOCK;
                else if (cnt_q >= GapLast) state_d = RUN;
            end
            RUN: if (abort) state_d = WAIT_LOCK;
            default: state_d = WAIT_LOCK;
        endcase
    end

    // Resets are registered images of the next state, so they move together.
    always_comb begin
        periph_d = (state_d == PERIPH_ON) || (state_d == RUN);
        core_d   = (state_d == RUN);
        cnt_d    = '0;
        if (state_d == state_q && state_q != WAIT_LOCK) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
        reason_d = reason_q;
        if (abort) begin
            priority case (1'b1)
                lock_lost: reason_d = ReasonLock;
                ext_press: reason_d = ReasonExt;
                default:   reason_d = ReasonSw;
            endcase
        end
    end

    assign rst_periph_no  = periph_q;
    assign rst_core_no    = core_q;
    assign reset_reason_o = reason_q;
    assign state_o        = {1'b0, state_q};

endmodule

// File: tb/tb_rst_seq_sonata.sv
// Bench for rst_seq_sonata: directed sequence checks plus random stimulus
// compared every cycle against a timeline-based reference model.
module tb_rst_seq_sonata;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int GAP  = 4;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic locked_i = 1'b1;
  logic ext_rst_ni = 1'b1;
  logic sw_rst_req_i = 1'b0;
  logic rst_periph_no, rst_core_no;
  logic [3:0] reset_reason_o;
  logic [2:0] state_o;

  int n_vec = 0;
  int n_err = 0;

  rst_seq_sonata #(
    .SyncStages(SYNC),
    .DebounceCycles(DEB),
    .HoldCycles(HOLD),
    .StageGap(GAP),
    .CntWidth(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .locked_i(locked_i),
    .ext_rst_ni(ext_rst_ni),
    .sw_rst_req_i(sw_rst_req_i),
    .rst_periph_no(rst_periph_no),
    .rst_core_no(rst_core_no),
    .reset_reason_o(reset_reason_o),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: sequence age since entering HOLD defines every output.
  logic [SYNC-1:0] lk_q = '0;
  logic [SYNC-1:0] ex_q = '0;
  bit   m_deb_rel = 1'b1;
  int   m_run = 0;
  bit   m_in_seq = 1'b0;
  int   m_age = 0;
  logic [3:0] m_reason = 4'b0001;

  function automatic int m_state();
    if (!m_in_seq) return 0;
    if (m_age < HOLD) return 1;
    if (m_age < HOLD + GAP) return 2;
    return 3;
  endfunction

  always @(posedge clk or posedge rst_i) begin : model
    bit ls, es, pressed;
    logic [3:0] cause;
    int st;
    if (rst_i) begin
      lk_q = '0;
      ex_q = '0;
      m_deb_rel = 1'b1;
      m_run = 0;
      m_in_seq = 1'b0;
      m_age = 0;
      m_reason = 4'b0001;
    end else begin
      ls = lk_q[SYNC-1];
      es = ex_q[SYNC-1];
      pressed = !m_deb_rel;
      st = m_state();
      lk_q = {lk_q[SYNC-2:0], locked_i};
      ex_q = {ex_q[SYNC-2:0], ext_rst_ni};
      if (es != m_deb_rel) begin
        m_run++;
        if (m_run == DEB) begin
          m_deb_rel = es;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      if (!ls) cause = 4'b0010;
      else if (pressed) cause = 4'b0100;
      else if (st == 3 && sw_rst_req_i) cause = 4'b1000;
      else cause = 4'b0000;
      if (!m_in_seq) begin
        if (ls && !pressed) begin
          m_in_seq = 1'b1;
          m_age = 0;
        end
      end else if (cause != 4'b0000) begin
        m_in_seq = 1'b0;
        m_reason = cause;
      end else if (m_age < HOLD + GAP) begin
        m_age++;
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_state", state_o, m_state());
    check("cmp_periph", rst_periph_no,
          m_in_seq && m_age >= HOLD);
    check("cmp_core", rst_core_no,
          m_in_seq && m_age >= HOLD + GAP);
    check("cmp_reason", reset_reason_o, m_reason);
    check("cmp_order", rst_core_no && !rst_periph_no, 0);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input int s, input int max,
                            input string name);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (state_o == s) break;
    end
    check(name, state_o, s);
  endtask

  int burst;

  initial begin
    // Power-up with lock present from the start.
    cyc(3);
    #1 rst_i = 1'b0;
    cyc(2);
    check("pu_wait_e2", state_o, 0);
    cyc(1);
    check("pu_hold_e3", state_o, 1);
    cyc(7);
    check("pu_periph_e10", rst_periph_no, 0);
    cyc(1);
    check("pu_periph_e11", rst_periph_no, 1);
    check("pu_state_e11", state_o, 2);
    cyc(3);
    check("pu_core_e14", rst_core_no, 0);
    cyc(1);
    check("pu_core_e15", rst_core_no, 1);
    check("pu_run_e15", state_o, 3);
    check("pu_reason", reset_reason_o, 4'b0001);

    // Late lock.
    #1 rst_i = 1'b1;
    locked_i = 1'b0;
    cyc(2);
    #1 rst_i = 1'b0;
    cyc(20);
    #1 locked_i = 1'b1;
    cyc(2);
    check("ll_wait_e22", state_o, 0);
    cyc(1);
    check("ll_hold_e23", state_o, 1);
    cyc(7);
    check("ll_periph_e30", rst_periph_no, 0);
    cyc(1);
    check("ll_periph_e31", rst_periph_no, 1);
    cyc(3);
    check("ll_core_e34", rst_core_no, 0);
    cyc(1);
    check("ll_core_e35", rst_core_no, 1);

    // Lock loss in RUN.
    #1 locked_i = 1'b0;
    cyc(2);
    check("lost_core_k2", rst_core_no, 1);
    cyc(1);
    check("lost_core_k3", rst_core_no, 0);
    check("lost_periph_k3", rst_periph_no, 0);
    check("lost_reason", reset_reason_o, 4'b0010);
    #1 locked_i = 1'b1;
    wait_state(3, 40, "lost_resequence");

    // Bouncy button: short lows must be filtered.
    repeat (3) begin
      #1 ext_rst_ni = 1'b0;
      cyc(3);
      #1 ext_rst_ni = 1'b1;
      cyc(1);
    end
    cyc(4);
    check("bounce_core", rst_core_no, 1);
    check("bounce_reason", reset_reason_o, 4'b0010);
    #1 ext_rst_ni = 1'b0;
    cyc(6);
    check("press_core_k6", rst_core_no, 1);
    cyc(1);
    check("press_core_k7", rst_core_no, 0);
    check("press_reason", reset_reason_o, 4'b0100);
    cyc(2);
    #1 ext_rst_ni = 1'b1;
    wait_state(3, 60, "press_resequence");

    // Software request in RUN, then ignored in HOLD.
    #1 sw_rst_req_i = 1'b1;
    cyc(1);
    check("sw_periph", rst_periph_no, 0);
    check("sw_reason", reset_reason_o, 4'b1000);
    #1 sw_rst_req_i = 1'b0;
    wait_state(1, 10, "sw_to_hold");
    #1 sw_rst_req_i = 1'b1;
    cyc(1);
    check("sw_ignored_state", state_o, 1);
    check("sw_ignored_reason", reset_reason_o, 4'b1000);
    #1 sw_rst_req_i = 1'b0;

    // Simultaneous lock drop and button press in RUN.
    wait_state(3, 40, "sim_run");
    #1 locked_i = 1'b0;
    ext_rst_ni = 1'b0;
    cyc(3);
    check("sim_periph", rst_periph_no, 0);
    check("sim_reason", reset_reason_o, 4'b0010);
    cyc(6);
    check("sim_reason_late", reset_reason_o, 4'b0010);
    #1 locked_i = 1'b1;
    ext_rst_ni = 1'b1;

    // Asynchronous reset mid-sequence.
    wait_state(2, 60, "por_periph_on");
    #3 rst_i = 1'b1;
    #1;
    check("por_periph", rst_periph_no, 0);
    check("por_core", rst_core_no, 0);
    check("por_state", state_o, 0);
    check("por_reason", reset_reason_o, 4'b0001);
    cyc(1);
    #1 rst_i = 1'b0;

    // Random stimulus.
    burst = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(0, 99) < 2) locked_i = ~locked_i;
      if (burst > 0) burst--;
      else if ($urandom_range(0, 99) < 2)
        burst = $urandom_range(1, 10);
      ext_rst_ni = (burst == 0);
      sw_rst_req_i = ($urandom_range(0, 99) < 4);
      rst_i = ($urandom_range(0, 999) < 4);
    end
    #1 rst_i = 1'b0;
    sw_rst_req_i = 1'b0;
    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
